// File: rtl/gen_clk_multi.sv
// rtl/gen_clk_multi.sv - multi-channel programmable clock/tick generator
module gen_clk_multi #(
  parameter int NCH        = 4,
  parameter int CW         = 32,
  parameter int SW         = 2,
  parameter int DEF_PERIOD = 25000000,
  parameter int DEF_HIGH   = 12500000
) (
  input  logic           iclk,
  input  logic           rst,
  input  logic [NCH-1:0] en,
  input  logic           wr_en,
  input  logic [SW-1:0]  wr_sel,
  input  logic [CW-1:0]  wr_period,
  input  logic [CW-1:0]  wr_high,
  output logic [NCH-1:0] oclk,
  output logic [NCH-1:0] otick,
  output logic [NCH-1:0] pend
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  // A period below 2 cannot produce both a tick and a distinct phase, so it is raised to 2.
  localparam logic [CW-1:0] DEF_P = (DEF_PERIOD < 2) ? CW'(2) : CW'(DEF_PERIOD);
  localparam logic [CW-1:0] DEF_H = CW'(DEF_HIGH);

  function automatic logic [CW-1:0] clamp_p(input logic [CW-1:0] p);
    return (p < CW'(2)) ? CW'(2) : p;
  endfunction

  state_t        state_q  [NCH];
  state_t        state_d  [NCH];
  logic [CW-1:0] cnt_q    [NCH];
  logic [CW-1:0] cnt_d    [NCH];
  logic [CW-1:0] period_q [NCH];
  logic [CW-1:0] period_d [NCH];
  logic [CW-1:0] high_q   [NCH];
  logic [CW-1:0] high_d   [NCH];
  logic [CW-1:0] pper_q   [NCH];
  logic [CW-1:0] pper_d   [NCH];
  logic [CW-1:0] phigh_q  [NCH];
  logic [CW-1:0] phigh_d  [NCH];
  logic [CW-1:0] cnt_nxt  [NCH];
  logic [NCH-1:0] oclk_q, oclk_d;
  logic [NCH-1:0] otick_q, otick_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] wr_hit;
  logic [NCH-1:0] wrap;

  // Decode the write target and the free-running counter successor for each channel.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      wr_hit[c]  = wr_en && (int'(wr_sel) == c);
      wrap[c]    = (cnt_q[c] == period_q[c] - CW'(1));
      cnt_nxt[c] = wrap[c] ? '0 : cnt_q[c] + CW'(1);
    end
  end

  // Per-channel next-state: run/idle control, boundary-aligned parameter update.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      state_d[c]  = state_q[c];
      cnt_d[c]    = cnt_q[c];
      period_d[c] = period_q[c];
      high_d[c]   = high_q[c];
      pper_d[c]   = pper_q[c];
      phigh_d[c]  = phigh_q[c];
      oclk_d[c]   = 1'b0;
      otick_d[c]  = 1'b0;
      pend_d[c]   = pend_q[c];
      case (state_q[c])
        ST_IDLE: begin
          cnt_d[c] = '0;
          if (wr_hit[c]) begin
            period_d[c] = clamp_p(wr_period);
            high_d[c]   = wr_high;
          end
          if (en[c]) begin
            state_d[c] = ST_RUN;
            oclk_d[c]  = (wr_hit[c] ? wr_high : high_q[c]) != '0;
            otick_d[c] = 1'b1;
          end
        end
        default: begin
          if (!en[c]) begin
            // Abandon the period; a freshest write beats an older pending one.
            state_d[c] = ST_IDLE;
            cnt_d[c]   = '0;
            pend_d[c]  = 1'b0;
            if (wr_hit[c]) begin
              period_d[c] = clamp_p(wr_period);
              high_d[c]   = wr_high;
            end else if (pend_q[c]) begin
              period_d[c] = clamp_p(pper_q[c]);
              high_d[c]   = phigh_q[c];
            end
          end else begin
            cnt_d[c]   = cnt_nxt[c];
            otick_d[c] = wrap[c];
            if (wrap[c] && pend_q[c]) begin
              period_d[c] = clamp_p(pper_q[c]);
              high_d[c]   = phigh_q[c];
              pend_d[c]   = 1'b0;
              oclk_d[c]   = phigh_q[c] != '0;
            end else begin
              oclk_d[c]   = cnt_nxt[c] < high_q[c];
            end
            if (wr_hit[c]) begin
              pper_d[c]  = wr_period;
              phigh_d[c] = wr_high;
              pend_d[c]  = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // State registers with synchronous reset to the default waveform.
  always_ff @(posedge iclk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        state_q[c]  <= ST_IDLE;
        cnt_q[c]    <= '0;
        period_q[c] <= DEF_P;
        high_q[c]   <= DEF_H;
        pper_q[c]   <= '0;
        phigh_q[c]  <= '0;
      end
      oclk_q  <= '0;
      otick_q <= '0;
      pend_q  <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        state_q[c]  <= state_d[c];
        cnt_q[c]    <= cnt_d[c];
        period_q[c] <= period_d[c];
        high_q[c]   <= high_d[c];
        pper_q[c]   <= pper_d[c];
        phigh_q[c]  <= phigh_d[c];
      end
      oclk_q  <= oclk_d;
      otick_q <= otick_d;
      pend_q  <= pend_d;
    end
  end

  assign oclk  = oclk_q;
  assign otick = otick_q;
  assign pend  = pend_q;

endmodule

// File: tb/tb_gen_clk_multi.sv
// tb/tb_gen_clk_multi.sv - randomized and directed bench with behavioural model
module tb_gen_clk_multi;
  localparam int NCH = 2;
  localparam int CW  = 8;
  localparam int SW  = 2;
  localparam int DP  = 10;
  localparam int DH  = 5;

  logic           iclk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] en = '0;
  logic           wr_en = 1'b0;
  logic [SW-1:0]  wr_sel = '0;
  logic [CW-1:0]  wr_period = '0;
  logic [CW-1:0]  wr_high = '0;
  logic [NCH-1:0] oclk, otick, pend;

  int checks = 0;
  int errors = 0;

  gen_clk_multi #(.NCH(NCH), .CW(CW), .SW(SW), .DEF_PERIOD(DP), .DEF_HIGH(DH)) dut (
    .iclk(iclk), .rst(rst), .en(en), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_period(wr_period), .wr_high(wr_high),
    .oclk(oclk), .otick(otick), .pend(pend)
  );

  always #5 iclk = ~iclk;

  // Model: phase within the period, active and pending settings per channel.
  int m_run [NCH];
  int m_ph  [NCH];
  int m_per [NCH];
  int m_hi  [NCH];
  int m_pp  [NCH];
  int m_phi [NCH];
  int m_pnd [NCH];
  bit m_valid = 0;
  logic [NCH-1:0] e_oclk, e_tick, e_pend;

  function automatic int clampi(input int p);
    return (p < 2) ? 2 : p;
  endfunction

  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      bit wr;
      wr = wr_en && (int'(wr_sel) == c);
      if (rst) begin
        m_run[c] = 0; m_ph[c] = 0; m_per[c] = clampi(DP); m_hi[c] = DH;
        m_pp[c] = 0; m_phi[c] = 0; m_pnd[c] = 0;
      end else if (m_run[c] == 0) begin
        if (wr) begin m_per[c] = clampi(int'(wr_period)); m_hi[c] = int'(wr_high); end
        if (en[c]) begin m_run[c] = 1; m_ph[c] = 0; end
      end else if (!en[c]) begin
        if (wr) begin m_per[c] = clampi(int'(wr_period)); m_hi[c] = int'(wr_high); end
        else if (m_pnd[c] != 0) begin m_per[c] = clampi(m_pp[c]); m_hi[c] = m_phi[c]; end
        m_run[c] = 0; m_ph[c] = 0; m_pnd[c] = 0;
      end else begin
        m_ph[c] = (m_ph[c] + 1) % m_per[c];
        if (m_ph[c] == 0 && m_pnd[c] != 0) begin
          m_per[c] = clampi(m_pp[c]); m_hi[c] = m_phi[c]; m_pnd[c] = 0;
        end
        if (wr) begin m_pp[c] = int'(wr_period); m_phi[c] = int'(wr_high); m_pnd[c] = 1; end
      end
      e_oclk[c] = (m_run[c] != 0) && (m_ph[c] < m_hi[c]);
      e_tick[c] = (m_run[c] != 0) && (m_ph[c] == 0);
      e_pend[c] = m_pnd[c] != 0;
    end
    if (rst) m_valid = 1;
  endtask

  // Every-cycle comparison of the DUT against the model, just after each edge.
  initial begin
    forever begin
      @(posedge iclk);
      model_step();
      #2;
      if (m_valid) begin
        checks++;
        if (oclk !== e_oclk) begin
          errors++;
          $display("FAIL oclk t=%0t got=%b exp=%b", $time, oclk, e_oclk);
        end
        checks++;
        if (otick !== e_tick) begin
          errors++;
          $display("FAIL otick t=%0t got=%b exp=%b", $time, otick, e_tick);
        end
        checks++;
        if (pend !== e_pend) begin
          errors++;
          $display("FAIL pend t=%0t got=%b exp=%b", $time, pend, e_pend);
        end
      end
    end
  end

  task automatic lit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge iclk);
  endtask

  task automatic wr(input int sel, input int p, input int h);
    wr_en = 1'b1; wr_sel = SW'(sel); wr_period = CW'(p); wr_high = CW'(h);
    cyc(1);
    wr_en = 1'b0;
  endtask

  task automatic wait_ph(input int ph_target, input bit last);
    int k;
    for (k = 0; k < 40; k++) begin
      if (m_run[0] != 0 && m_ph[0] == (last ? m_per[0] - 1 : ph_target)) break;
      cyc(1);
    end
    if (k == 40) begin
      checks++;
      errors++;
      $display("FAIL wait_phase timeout got=%0d exp=%0d", m_ph[0], ph_target);
    end
  endtask

  initial begin
    // Reset defaults: period 10, high 5 on ch0, ch1 idle
    cyc(2);
    rst = 1'b0; en = 2'b01;
    cyc(1);
    lit("def_first_rise", oclk[0], 1'b1);
    lit("def_first_tick", otick[0], 1'b1);
    cyc(5);
    lit("def_low_at_5", oclk[0], 1'b0);
    lit("def_no_tick_5", otick[0], 1'b0);
    cyc(5);
    lit("def_tick_at_11", otick[0], 1'b1);
    lit("def_ch1_idle", oclk[1], 1'b0);
    cyc(12);

    // Idle write period 5 high 2
    en = 2'b00; cyc(2);
    wr(0, 5, 2);
    en = 2'b01; cyc(1);
    lit("idle_wr_rise", oclk[0], 1'b1);
    cyc(2);
    lit("idle_wr_low_ph2", oclk[0], 1'b0);
    lit("idle_wr_no_pend", pend[0], 1'b0);
    cyc(3);
    lit("idle_wr_tick_en6", otick[0], 1'b1);
    cyc(7);

    // Running write mid-period
    wait_ph(1, 0);
    wr(0, 3, 1);
    lit("run_wr_pend", pend[0], 1'b1);
    cyc(12);

    // Write on a wrap cycle, with an earlier value already pending
    wait_ph(1, 0);
    wr(0, 4, 2);
    wait_ph(0, 1);
    wr(0, 6, 3);
    lit("wrap_wr_pend_kept", pend[0], 1'b1);
    lit("wrap_wr_tick", otick[0], 1'b1);
    cyc(16);

    // Boundaries: period 0 / high 0, then high beyond period
    wr(0, 0, 0);
    cyc(10);
    lit("p0_oclk_low", oclk[0], 1'b0);
    wr(0, 4, 9);
    cyc(10);
    lit("hi9_oclk_high", oclk[0], 1'b1);
    wr(3, 7, 1);
    cyc(6);

    // Disable at cnt 2, re-enable
    wr(0, 6, 3);
    cyc(8);
    wait_ph(2, 0);
    en[0] = 1'b0; cyc(1);
    lit("dis_oclk_low", oclk[0], 1'b0);
    cyc(2);
    en[0] = 1'b1; cyc(4);

    // Reset while both run with pending writes
    en = 2'b11; cyc(3);
    wr(0, 3, 1);
    wr(1, 4, 2);
    rst = 1'b1; cyc(1);
    lit("rst_pend0", pend[0], 1'b0);
    lit("rst_oclk1", oclk[1], 1'b0);
    rst = 1'b0; cyc(4);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 24) == 0) en[c] = ~en[c];
      wr_en = ($urandom_range(0, 3) == 0);
      wr_sel = SW'($urandom_range(0, 3));
      wr_period = CW'($urandom_range(0, 12));
      wr_high = CW'($urandom_range(0, 14));
      cyc(1);
    end
    rst = 1'b0; wr_en = 1'b0;
    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
